// File: rtl/optical_slot_gate_if.sv
// AXI-Stream bundle used on both sides of optical_slot_gate.
// master drives data/valid/last, slave drives ready.
interface optical_slot_gate_if #(
  parameter int DATA_WIDTH = 64
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic                    tvalid;
  logic                    tready;
  logic                    tlast;

  modport master (output tdata, output tstrb, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tstrb, input tvalid, input tlast, output tready);
endinterface

// File: rtl/optical_slot_gate.sv
// Circuit-slot gate: buffers stream words and releases whole packets only while the
// optical circuit is up. Optional macro SLOT_GATE_DROP_EN selects drop-on-full admission.
module optical_slot_gate #(
  parameter int C_M_AXIS_DATA_WIDTH = 64,
  parameter int C_S_AXIS_DATA_WIDTH = 64,
  parameter int C_FIFO_DEPTH_LOG2   = 6,
  parameter int C_DAY_CYCLES        = 1000,
  parameter int C_NIGHT_CYCLES      = 20,
  parameter int C_MAX_PKT_WORDS     = 16
) (
  input  logic                        axi_aclk,
  input  logic                        axi_aresetn,
  optical_slot_gate_if.slave          s_axis,
  optical_slot_gate_if.master         m_axis,
  input  logic                        count_reset,
  output logic                        circuit_up,
  output logic [31:0]                 pkt_count,
  output logic [31:0]                 drop_count
);

  localparam int DW       = C_M_AXIS_DATA_WIDTH;
  localparam int STRB_W   = DW / 8;
  localparam int WORD_W   = DW + STRB_W + 1;
  localparam int ADDR_W   = C_FIFO_DEPTH_LOG2;
  localparam int PTR_W    = C_FIFO_DEPTH_LOG2 + 1;
  localparam int DEPTH    = 1 << C_FIFO_DEPTH_LOG2;
  localparam int SLOT_MAX = (C_DAY_CYCLES > C_NIGHT_CYCLES) ? C_DAY_CYCLES : C_NIGHT_CYCLES;
  localparam int SLOT_W   = (SLOT_MAX > 2) ? $clog2(SLOT_MAX) : 1;

  localparam logic [SLOT_W-1:0] DAY_RELOAD   = SLOT_W'(C_DAY_CYCLES - 1);
  localparam logic [SLOT_W-1:0] NIGHT_RELOAD = SLOT_W'(C_NIGHT_CYCLES - 1);
  localparam logic [SLOT_W-1:0] SLOT_ONE     = SLOT_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE      = PTR_W'(1);
  localparam logic [32:0]       MAX_PKT_EXT  = 33'(C_MAX_PKT_WORDS);

  typedef enum logic {SLOT_DAY, SLOT_NIGHT} slot_e;
  typedef enum logic {OUT_IDLE, OUT_PKT} out_state_e;

  slot_e                slot_r;
  logic [SLOT_W-1:0]    slot_cnt_r;
  logic                 circuit_up_r;

  logic [WORD_W-1:0]    mem_r [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [PTR_W-1:0]     wr_ptr_next_s;
  logic [PTR_W-1:0]     rd_ptr_next_s;
  logic                 full_r;
  logic                 empty_r;
  logic                 full_next_s;
  logic                 empty_next_s;
  logic                 wr_en_s;
  logic                 rd_en_s;
  logic [WORD_W-1:0]    head_s;
  logic                 head_tlast_s;

  out_state_e           state_r;
  out_state_e           state_next_s;
  logic                 m_valid_r;
  logic                 m_valid_next_s;
  logic                 fits_s;
  logic                 pkt_done_s;
  logic [31:0]          pkt_count_r;

  assign head_s       = mem_r[rd_ptr_r[ADDR_W-1:0]];
  assign head_tlast_s = head_s[WORD_W-1];

  assign m_axis.tdata  = head_s[DW-1:0];
  assign m_axis.tstrb  = head_s[DW +: STRB_W];
  assign m_axis.tlast  = head_tlast_s;
  assign m_axis.tvalid = m_valid_r;
  assign circuit_up    = circuit_up_r;
  assign pkt_count     = pkt_count_r;

  // Free-running DAY/NIGHT slot timer; circuit_up tracks the slot register exactly
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      slot_r       <= SLOT_DAY;
      slot_cnt_r   <= DAY_RELOAD;
      circuit_up_r <= 1'b1;
    end else if (slot_cnt_r == '0) begin
      if (slot_r == SLOT_DAY) begin
        slot_r       <= SLOT_NIGHT;
        slot_cnt_r   <= NIGHT_RELOAD;
        circuit_up_r <= 1'b0;
      end else begin
        slot_r       <= SLOT_DAY;
        slot_cnt_r   <= DAY_RELOAD;
        circuit_up_r <= 1'b1;
      end
    end else begin
      slot_cnt_r <= slot_cnt_r - SLOT_ONE;
    end
  end

`ifdef SLOT_GATE_DROP_EN
  logic              in_pkt_r;
  logic              dropping_r;
  logic [31:0]       drop_count_r;
  logic [PTR_W-1:0]  used_s;
  logic [PTR_W-1:0]  free_s;
  logic              drop_start_s;

  assign used_s        = wr_ptr_r - rd_ptr_r;
  assign free_s        = PTR_W'(DEPTH) - used_s;
  assign drop_start_s  = s_axis.tvalid && !in_pkt_r && (32'(free_s) < 32'(C_MAX_PKT_WORDS));
  assign wr_en_s       = s_axis.tvalid && !full_r && !dropping_r && !drop_start_s;
  assign s_axis.tready = 1'b1;
  assign drop_count    = drop_count_r;

  // Admission tracking: the decision made at a packet's first word holds through its tlast
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      in_pkt_r   <= 1'b0;
      dropping_r <= 1'b0;
    end else if (s_axis.tvalid) begin
      in_pkt_r <= !s_axis.tlast;
      if (s_axis.tlast) begin
        dropping_r <= 1'b0;
      end else if (drop_start_s) begin
        dropping_r <= 1'b1;
      end
    end
  end

  // Dropped-packet counter; a clear beats a simultaneous drop
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      drop_count_r <= 32'd0;
    end else if (count_reset) begin
      drop_count_r <= 32'd0;
    end else if (drop_start_s) begin
      drop_count_r <= drop_count_r + 32'd1;
    end
  end
`else
  assign wr_en_s       = s_axis.tvalid && !full_r;
  assign s_axis.tready = !full_r;
  assign drop_count    = 32'd0;
`endif

  // Word storage; flushed on reset so the head never presents stale data
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (wr_en_s) begin
      mem_r[wr_ptr_r[ADDR_W-1:0]] <= {s_axis.tlast, s_axis.tstrb, s_axis.tdata};
    end
  end

  // Next pointers and the flags they imply; flags are registered from these
  always_comb begin
    wr_ptr_next_s = wr_ptr_r;
    rd_ptr_next_s = rd_ptr_r;
    if (wr_en_s) begin
      wr_ptr_next_s = wr_ptr_r + PTR_ONE;
    end else begin
      wr_ptr_next_s = wr_ptr_r;
    end
    if (rd_en_s) begin
      rd_ptr_next_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_next_s = rd_ptr_r;
    end
    full_next_s  = (wr_ptr_next_s[PTR_W-1] != rd_ptr_next_s[PTR_W-1]) &&
                   (wr_ptr_next_s[ADDR_W-1:0] == rd_ptr_next_s[ADDR_W-1:0]);
    empty_next_s = (wr_ptr_next_s == rd_ptr_next_s);
  end

  // FIFO pointer and flag registers
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      wr_ptr_r <= wr_ptr_next_s;
      rd_ptr_r <= rd_ptr_next_s;
      full_r   <= full_next_s;
      empty_r  <= empty_next_s;
    end
  end

  // A packet may start only if the remaining DAY time covers the largest packet
  assign fits_s = (33'(slot_cnt_r) + 33'd1) >= MAX_PKT_EXT;

  // Output FSM next-state: idle until a packet can start, then drain it to tlast
  always_comb begin
    state_next_s = state_r;
    rd_en_s      = 1'b0;
    pkt_done_s   = 1'b0;
    case (state_r)
      OUT_IDLE: begin
        if (!empty_r && (slot_r == SLOT_DAY) && fits_s) begin
          state_next_s = OUT_PKT;
        end else begin
          state_next_s = OUT_IDLE;
        end
      end
      OUT_PKT: begin
        if (m_valid_r && m_axis.tready) begin
          rd_en_s = 1'b1;
          if (head_tlast_s) begin
            pkt_done_s   = 1'b1;
            state_next_s = OUT_IDLE;
          end else begin
            state_next_s = OUT_PKT;
          end
        end else begin
          state_next_s = OUT_PKT;
        end
      end
      default: begin
        state_next_s = OUT_IDLE;
      end
    endcase
  end

  // Registered valid equals "in a packet and FIFO not empty" one cycle ahead
  always_comb begin
    m_valid_next_s = 1'b0;
    if (state_next_s == OUT_PKT) begin
      m_valid_next_s = !empty_next_s;
    end else begin
      m_valid_next_s = 1'b0;
    end
  end

  // Output FSM state and valid registers
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_r   <= OUT_IDLE;
      m_valid_r <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      m_valid_r <= m_valid_next_s;
    end
  end

  // Emitted-packet counter; a clear beats a simultaneous tlast beat
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      pkt_count_r <= 32'd0;
    end else if (count_reset) begin
      pkt_count_r <= 32'd0;
    end else if (pkt_done_s) begin
      pkt_count_r <= pkt_count_r + 32'd1;
    end
  end

endmodule

// File: tb/tb_optical_slot_gate.sv
// Directed bench for optical_slot_gate with a queue-based reference model checked every cycle.
// Build with or without +define+SLOT_GATE_DROP_EN.
module tb_optical_slot_gate;
  localparam int DW    = 64;
  localparam int DAY   = 64;
  localparam int NIGHT = 16;
  localparam int MAXP  = 16;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        count_reset = 1'b0;
  logic        circuit_up;
  logic [31:0] pkt_count;
  logic [31:0] drop_count;

  always #5 clk = ~clk;

  optical_slot_gate_if #(.DATA_WIDTH(DW)) s_if ();
  optical_slot_gate_if #(.DATA_WIDTH(DW)) m_if ();

  optical_slot_gate #(
    .C_M_AXIS_DATA_WIDTH(DW), .C_S_AXIS_DATA_WIDTH(DW), .C_FIFO_DEPTH_LOG2(6),
    .C_DAY_CYCLES(DAY), .C_NIGHT_CYCLES(NIGHT), .C_MAX_PKT_WORDS(MAXP)
  ) dut (
    .axi_aclk(clk), .axi_aresetn(rst_n), .s_axis(s_if), .m_axis(m_if),
    .count_reset(count_reset), .circuit_up(circuit_up),
    .pkt_count(pkt_count), .drop_count(drop_count)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // reference model state: queued words {tlast, tstrb, tdata}
  logic [72:0] q[$];
  logic [72:0] src_q[$];
  int  cyc = 0;
  int  src_from = 0;
  bit  in_pkt = 1'b0;
  int  m_pkt = 0;
  int  m_drop = 0;
  int  words_out = 0;
  int  first_beat = -1;
  bit  accepted = 1'b0;
`ifdef SLOT_GATE_DROP_EN
  bit  src_in_pkt = 1'b0;
  bit  discard = 1'b0;
`endif

  function automatic bit is_day(int c);
    return (c % (DAY + NIGHT)) < DAY;
  endfunction

  function automatic int slot_left(int c);
    int ph;
    ph = c % (DAY + NIGHT);
    return (ph < DAY) ? (DAY - 1 - ph) : (DAY + NIGHT - 1 - ph);
  endfunction

  function automatic logic [72:0] mk(int p, int i, int n);
    logic [7:0] st;
    st = 8'hA5 ^ 8'(i * 29 + p);
    return {(i == n - 1), st, 16'hC0DE, 16'(p), 32'(i)};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic send(int p, int n);
    for (int i = 0; i < n; i++) src_q.push_back(mk(p, i, n));
  endtask

  // compare DUT against the model for the current cycle, then advance the model one clock
  task automatic tick();
    bit exp_valid, exp_sready, wr, beat;
    int qs;
    logic [72:0] w;
    qs = q.size();
    exp_valid = in_pkt && (qs > 0);
`ifdef SLOT_GATE_DROP_EN
    exp_sready = 1'b1;
`else
    exp_sready = (qs < DEPTH);
`endif
    check("s_tready", 64'(s_if.tready), 64'(exp_sready));
    check("m_tvalid", 64'(m_if.tvalid), 64'(exp_valid));
    check("circuit_up", 64'(circuit_up), 64'(is_day(cyc)));
    check("pkt_count", 64'(pkt_count), 64'(m_pkt));
    check("drop_count", 64'(drop_count), 64'(m_drop));
    if (exp_valid) begin
      check("m_tdata", m_if.tdata, q[0][63:0]);
      check("m_tstrb", 64'(m_if.tstrb), 64'(q[0][71:64]));
      check("m_tlast", 64'(m_if.tlast), 64'(q[0][72]));
    end
    wr = 1'b0;
    accepted = s_if.tvalid && exp_sready;
    if (s_if.tvalid) begin
`ifdef SLOT_GATE_DROP_EN
      if (!src_in_pkt) begin
        discard = (DEPTH - qs) < MAXP;
        if (discard) m_drop++;
      end
      wr = !discard && (qs < DEPTH);
      src_in_pkt = !s_if.tlast;
`else
      wr = exp_sready;
`endif
    end
    beat = exp_valid && m_if.tready;
    if (beat) begin
      w = q.pop_front();
      words_out++;
      if (first_beat < 0) first_beat = cyc;
      if (w[72]) begin
        in_pkt = 1'b0;
        m_pkt++;
      end
    end else if (!in_pkt && qs > 0 && is_day(cyc) && slot_left(cyc) + 1 >= MAXP) begin
      in_pkt = 1'b1;
    end
    if (count_reset) begin
      m_pkt = 0;
      m_drop = 0;
    end
    if (wr) q.push_back({s_if.tlast, s_if.tstrb, s_if.tdata});
    cyc++;
    @(negedge clk);
  endtask

  task automatic step();
    logic [72:0] tmp;
    if (src_q.size() > 0 && cyc >= src_from) begin
      s_if.tvalid = 1'b1;
      {s_if.tlast, s_if.tstrb, s_if.tdata} = src_q[0];
    end else begin
      s_if.tvalid = 1'b0;
    end
    tick();
    if (accepted) tmp = src_q.pop_front();
  endtask

  task automatic run_until(int c);
    while (cyc < c) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    s_if.tvalid = 1'b0;
    q.delete();
    src_q.delete();
    in_pkt = 1'b0;
    m_pkt = 0;
    m_drop = 0;
    words_out = 0;
    first_beat = -1;
`ifdef SLOT_GATE_DROP_EN
    src_in_pkt = 1'b0;
    discard = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    int exp_words, exp_pkts;
    s_if.tvalid = 1'b0;
    s_if.tdata = '0;
    s_if.tstrb = '0;
    s_if.tlast = 1'b0;
    m_if.tready = 1'b1;
    do_reset();

    // reset state and slot schedule
    check("rst_circuit_up", 64'(circuit_up), 64'd1);
    check("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
    check("rst_s_tready", 64'(s_if.tready), 64'd1);
    check("rst_pkt_count", 64'(pkt_count), 64'd0);

    // 16-word packet from cycle 5: first beat cycle 7
    src_from = 5;
    send(1, 16);
    run_until(23);
    check("first_beat_c7", 64'(first_beat), 64'd7);
    check("pkt_after_16w", 64'(pkt_count), 64'd1);

    // packet queued with 10 cycles of DAY left waits for the next DAY
    first_beat = -1;
    src_from = 52;
    send(2, 4);
    run_until(53);
    check("late_no_valid", 64'(m_if.tvalid), 64'd0);
    run_until(63);
    check("cu_high_63", 64'(circuit_up), 64'd1);
    run_until(64);
    check("cu_low_64", 64'(circuit_up), 64'd0);
    run_until(79);
    check("cu_low_79", 64'(circuit_up), 64'd0);
    run_until(80);
    check("cu_high_80", 64'(circuit_up), 64'd1);
    run_until(86);
    check("late_first_beat_c81", 64'(first_beat), 64'd81);
    check("pkt_after_late", 64'(pkt_count), 64'd2);

    // reset pulse in the middle of a packet
    src_from = 90;
    send(3, 8);
    run_until(95);
    check("mid_pkt_valid", 64'(m_if.tvalid), 64'd1);
    do_reset();
    check("flush_m_tvalid", 64'(m_if.tvalid), 64'd0);
    check("flush_pkt_count", 64'(pkt_count), 64'd0);
    check("flush_s_tready", 64'(s_if.tready), 64'd1);
    run_until(10);

    // count_reset coinciding with a tlast beat (beats at 12..14)
    src_from = 10;
    send(4, 3);
    run_until(14);
    count_reset = 1'b1;
    step();
    count_reset = 1'b0;
    check("clr_wins_pkt", 64'(pkt_count), 64'd0);
    src_from = 20;
    send(5, 2);
    run_until(25);
    check("count_after_clr", 64'(pkt_count), 64'd1);

    // five 16-word packets against a stalled sink
    do_reset();
    m_if.tready = 1'b0;
    src_from = 2;
    for (int p = 0; p < 5; p++) send(10 + p, 16);
    run_until(70);
`ifdef SLOT_GATE_DROP_EN
    check("drop_tready_high", 64'(s_if.tready), 64'd1);
    check("drop_count_1", 64'(drop_count), 64'd1);
    exp_words = 64;
    exp_pkts  = 4;
`else
    check("full_tready_low", 64'(s_if.tready), 64'd0);
    exp_words = 80;
    exp_pkts  = 5;
`endif
    run_until(100);
    m_if.tready = 1'b1;
    while (words_out < exp_words && cyc < 1000) step();
    if (cyc >= 1000) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drain_timeout words_out=%0d required=%0d", words_out, exp_words);
    end
    run_until(cyc + 3);
    check("drain_words", 64'(words_out), 64'(exp_words));
    check("drain_pkts", 64'(pkt_count), 64'(exp_pkts));
    check("drain_fifo_empty", 64'(m_if.tvalid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
